// File: rtl/instr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : instr_issuer
// Purpose  : Buffers host instruction words in a DEPTH-entry FIFO and, once
//            started, issues them one per cycle to the control unit.
//            LOAD_WEIGHT words are held for LOAD_CYCLES cycles and then
//            followed by one NOP bubble. HALT returns the issuer to IDLE
//            without ever appearing on the output.
// Ports    : clk         - single clock, rising edge
//            reset       - synchronous, active-high
//            host_valid  - host offers host_instr this cycle
//            host_instr  - [15:13] opcode, [12:0] operand
//            host_ready  - FIFO has room (push = host_valid && host_ready)
//            start       - one-cycle pulse, honoured only in IDLE
//            instruction - registered word driven to the control unit
//            busy        - high whenever the issuer is not IDLE
//            fifo_count  - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module instr_issuer #(
  parameter int DEPTH       = 8,
  parameter int LOAD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_valid,
  input  logic [15:0]              host_instr,
  output logic                     host_ready,
  input  logic                     start,
  output logic [15:0]              instruction,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LOAD_CYCLES + 1);

  localparam logic [2:0] OP_NOP         = 3'b000;
  localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
  localparam logic [2:0] OP_HALT        = 3'b111;

  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
  // Counter preload: the issue cycle already shows the word once, so HOLD
  // must cover the remaining LOAD_CYCLES-1 cycles (counter runs N-2 .. 0).
  localparam logic [CW-1:0] HOLD_INIT = (LOAD_CYCLES >= 2) ? CW'(LOAD_CYCLES - 2) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    HOLD   = 2'd2,
    BUBBLE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   hold_cnt, hold_cnt_nxt;
  logic [15:0]     instr_nxt;
  logic [15:0]     head;
  logic            push, pop;

  assign host_ready = (count < DEPTH_L);
  assign push       = host_valid && host_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE);
  assign fifo_count = count;

  // Next-state / output decode. Pop decisions use the registered count, so a
  // word written this cycle can never be issued in the same cycle.
  always_comb begin
    state_nxt    = state;
    instr_nxt    = instruction;
    hold_cnt_nxt = hold_cnt;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        instr_nxt = 16'h0000;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (count == '0) begin
          instr_nxt = 16'h0000;
        end else begin
          pop = 1'b1;
          case (head[15:13])
            OP_HALT: begin
              instr_nxt = 16'h0000;
              state_nxt = IDLE;
            end
            OP_LOAD_WEIGHT: begin
              instr_nxt = head;
              if (LOAD_CYCLES == 1) begin
                state_nxt = BUBBLE;
              end else begin
                state_nxt    = HOLD;
                hold_cnt_nxt = HOLD_INIT;
              end
            end
            OP_NOP:  instr_nxt = 16'h0000;
            default: instr_nxt = head;
          endcase
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_nxt = BUBBLE;
        else                hold_cnt_nxt = hold_cnt - CW'(1);
      end
      BUBBLE: begin
        instr_nxt = 16'h0000;
        state_nxt = ISSUE;
      end
      default: begin
        state_nxt = IDLE;
        instr_nxt = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instruction <= 16'h0000;
      hold_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_nxt;
      instruction <= instr_nxt;
      hold_cnt    <= hold_cnt_nxt;
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= host_instr;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_issuer
// Purpose  : Self-checking bench for instr_issuer (DEPTH=8, LOAD_CYCLES=4).
//            A per-cycle vector table covers reset, ordinary issue, HALT,
//            LOAD_WEIGHT hold/bubble, NOP and unknown opcodes, FIFO full and
//            start/reset interaction; hand-written sequences cover
//            simultaneous push/pop with pointer wrap and reset mid-HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_valid;
  logic [15:0] host_instr;
  logic        host_ready;
  logic        start;
  logic [15:0] instruction;
  logic        busy;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  instr_issuer #(.DEPTH(8), .LOAD_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_instr  (host_instr),
    .host_ready  (host_ready),
    .start       (start),
    .instruction (instruction),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hv;
    logic [15:0] hi;
    logic        st;
    logic [15:0] e_instr;
    logic        e_busy;
    logic [3:0]  e_cnt;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic hv, input logic [15:0] hi, input logic st,
                     input logic [15:0] e_instr, input logic e_busy, input logic [3:0] e_cnt,
                     input logic e_ready);
    vec_t v;
    v.rst = rst; v.hv = hv; v.hi = hi; v.st = st;
    v.e_instr = e_instr; v.e_busy = e_busy; v.e_cnt = e_cnt; v.e_ready = e_ready;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then let outputs settle before checks.
  task automatic step(input logic rst, input logic hv, input logic [15:0] hi, input logic st);
    reset = rst; host_valid = hv; host_instr = hi; start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ei, input logic eb,
                         input logic [3:0] ec, input logic er);
    chk({tag, ".instruction"}, {16'h0, instruction}, {16'h0, ei});
    chk({tag, ".busy"},        {31'h0, busy},        {31'h0, eb});
    chk({tag, ".fifo_count"},  {28'h0, fifo_count},  {28'h0, ec});
    chk({tag, ".host_ready"},  {31'h0, host_ready},  {31'h0, er});
  endtask

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_instr = 16'h0; start = 1'b0;

    //   rst hv  hi        st   instr     busy cnt  ready
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 4'd0, 1);   // reset state
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 4'd0, 1);   // ready right after reset
    // ordinary words followed by HALT
    add(0, 1, 16'h2005, 0, 16'h0000, 0, 4'd1, 1);
    add(0, 1, 16'h2010, 0, 16'h0000, 0, 4'd2, 1);
    add(0, 1, 16'hE000, 0, 16'h0000, 0, 4'd3, 1);
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 4'd3, 1);
    add(0, 0, 16'h0000, 0, 16'h2005, 1, 4'd2, 1);
    add(0, 0, 16'h0000, 0, 16'h2010, 1, 4'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 4'd0, 1);   // HALT consumed, back to IDLE
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 4'd0, 1);
    // LOAD_WEIGHT: 4 cycles held, one bubble, then next word
    add(0, 1, 16'h4000, 0, 16'h0000, 0, 4'd1, 1);
    add(0, 1, 16'h2001, 0, 16'h0000, 0, 4'd2, 1);
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 4'd2, 1);
    add(0, 0, 16'h0000, 0, 16'h4000, 1, 4'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h4000, 1, 4'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h4000, 1, 4'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h4000, 1, 4'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 4'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h2001, 1, 4'd0, 1);
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 4'd0, 1);   // empty ISSUE; start ignored
    add(0, 1, 16'hE000, 0, 16'h0000, 1, 4'd1, 1);   // pushed word not yet poppable
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 4'd0, 1);
    // unknown opcode passes through, NOP issued as zero
    add(0, 1, 16'h6ABC, 0, 16'h0000, 0, 4'd1, 1);
    add(0, 1, 16'h0123, 0, 16'h0000, 0, 4'd2, 1);
    add(0, 1, 16'hE000, 0, 16'h0000, 0, 4'd3, 1);
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 4'd3, 1);
    add(0, 0, 16'h0000, 0, 16'h6ABC, 1, 4'd2, 1);
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 4'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 4'd0, 1);
    // fill FIFO to DEPTH; ninth word refused
    add(0, 1, 16'h2100, 0, 16'h0000, 0, 4'd1, 1);
    add(0, 1, 16'h2101, 0, 16'h0000, 0, 4'd2, 1);
    add(0, 1, 16'h2102, 0, 16'h0000, 0, 4'd3, 1);
    add(0, 1, 16'h2103, 0, 16'h0000, 0, 4'd4, 1);
    add(0, 1, 16'h2104, 0, 16'h0000, 0, 4'd5, 1);
    add(0, 1, 16'h2105, 0, 16'h0000, 0, 4'd6, 1);
    add(0, 1, 16'h2106, 0, 16'h0000, 0, 4'd7, 1);
    add(0, 1, 16'h2107, 0, 16'h0000, 0, 4'd8, 0);
    add(0, 1, 16'h2FFF, 0, 16'h0000, 0, 4'd8, 0);
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 4'd8, 0);
    add(0, 0, 16'h0000, 0, 16'h2100, 1, 4'd7, 1);   // first pop frees a slot
    add(0, 0, 16'h0000, 0, 16'h2101, 1, 4'd6, 1);
    // start in same cycle as reset: reset wins, start lost
    add(1, 0, 16'h0000, 1, 16'h0000, 0, 4'd0, 1);
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 4'd0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].hv, vecs[i].hi, vecs[i].st);
      chk_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_ready);
    end

    // Simultaneous push/pop at count 3; 20 words through an 8-deep FIFO.
    step(0, 1, 16'h2200, 0);
    step(0, 1, 16'h2201, 0);
    step(0, 1, 16'h2202, 0);
    step(0, 0, 16'h0000, 1);
    chk("wrap.start_cnt", {28'h0, fifo_count}, 32'd3);
    for (int c = 0; c < 20; c++) begin
      if (c < 17) step(0, 1, 16'h2203 + 16'(c), 0);
      else        step(0, 0, 16'h0000, 0);
      chk($sformatf("wrap.instr%0d", c), {16'h0, instruction}, {16'h0, 16'h2200 + 16'(c)});
      chk($sformatf("wrap.cnt%0d", c), {28'h0, fifo_count}, (c < 17) ? 32'd3 : 32'(19 - c));
    end
    step(0, 0, 16'h0000, 0);
    chk_all("wrap.empty", 16'h0000, 1'b1, 4'd0, 1'b1);
    step(0, 1, 16'hE000, 0);
    step(0, 0, 16'h0000, 0);
    chk_all("wrap.halt", 16'h0000, 1'b0, 4'd0, 1'b1);

    // Reset during the second HOLD cycle of a LOAD_WEIGHT.
    step(0, 1, 16'h4000, 0);
    step(0, 1, 16'h2001, 0);
    step(0, 0, 16'h0000, 1);
    step(0, 0, 16'h0000, 0);
    chk("hold.first", {16'h0, instruction}, {16'h0, 16'h4000});
    step(0, 0, 16'h0000, 0);
    chk("hold.second", {16'h0, instruction}, {16'h0, 16'h4000});
    step(1, 0, 16'h0000, 0);
    chk_all("hold.reset", 16'h0000, 1'b0, 4'd0, 1'b1);
    step(0, 0, 16'h0000, 1);
    chk("hold.restart_busy", {31'h0, busy}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 16'h0000, 0);
      chk_all($sformatf("hold.nop%0d", c), 16'h0000, 1'b1, 4'd0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
